screen_compositor: RTL
======================

// Module: screen_compositor
// PURPOSE
//  Parametrised VGA screen compositor: replaces the fixed priority RGB mux that picks between game screens.
//  Selects one of NUM_LAYERS full-screen sources as base, crossfades between bases over 2^FADE_LOG2 frames,
//  overlays keyed layers (transparent where pixel == key colour), and delays hsync/vsync/blank to match.
//  Sits between the per-screen draw modules and the VGA pin wiring; clocked on the 65 MHz pixel clock.
// PARAMETERS
//  NUM_LAYERS  4   number of RGB sources (>=2); SEL_W = $clog2(NUM_LAYERS)
//  FADE_LOG2   4   crossfade length = 2^FADE_LOG2 frames; 0 = instant switch, no FADING state
// PORTS
//  clk_in          in   1              pixel clock
//  rst_in          in   1              synchronous active-high reset
//  frame_trigger_in in  1              one-cycle pulse per frame (hcount==1 && vcount==1)
//  hsync_in        in   1              timing from xvga
//  vsync_in        in   1
//  blank_in        in   1
//  layer_rgb_in    in   12*NUM_LAYERS  layer i at [12*i+11:12*i], 4:4:4 RGB
//  sel_in          in   SEL_W          requested base layer
//  overlay_en_in   in   NUM_LAYERS     layer i drawn as keyed overlay when 1 (ignored for the current base)
//  key_color_in    in   12             transparent colour for overlays
//  rgb_out         out  12             composited pixel, 0 while blank_out=1
//  hsync_out       out  1              hsync_in delayed 2 cycles
//  vsync_out       out  1              vsync_in delayed 2 cycles
//  blank_out       out  1              blank_in delayed 2 cycles
//  fade_busy_out   out  1              1 while in FADING
// BEHAVIOUR
//  - Reset: rgb_out=0, hsync_out=0, vsync_out=0, blank_out=1, fade_busy_out=0, cur_sel=0, from_sel=0, k=0, state IDLE.
//  - Latency fixed at 2 cycles for rgb and all sync outputs; stage 1 registers from/to/overlay pixels, k, syncs;
//    stage 2 blends, applies overlay and blank, registers outputs.
//  - sel_in sampled only on frame_trigger_in; sel_in >= NUM_LAYERS ignored (selection unchanged).
//  - States: IDLE, FADING.
//    IDLE: trigger with valid sel_in != cur_sel -> from_sel<=cur_sel, cur_sel<=sel_in, k<=0, FADING
//          (FADE_LOG2=0: cur_sel updated, stay IDLE).
//    FADING: each trigger k<=k+1; trigger at k==2^FADE_LOG2-1 -> IDLE. Valid sel_in != cur_sel on a trigger
//          restarts: from_sel<=cur_sel, cur_sel<=sel_in, k<=0 (visible step accepted). sel_in==cur_sel: continue.
//  - Base pixel: IDLE -> layer[cur_sel]; FADING -> per 4-bit channel
//    c = (from*(2^L - k) + to*k) >> L, L=FADE_LOG2, intermediate width 4+L+1, truncation; never exceeds 15.
//  - Overlay: highest index i with overlay_en_in[i]=1, i != cur_sel, layer[i] != key_color_in wins; else base.
//  - blank (stage-aligned) forces rgb_out=0 regardless of layers.
//  - fade_busy_out = (state==FADING), registered, changes in the cycle after the trigger.
//  - Reset mid-fade: immediate return to reset values; layer 0 shown once blank_out drops.
// TESTING
//  1. Assert rst_in 3 cycles -> rgb_out=0, blank_out=1, fade_busy_out=0; then sel=0 shows layer0 unfaded.
//  2. sel_in=2 + trigger, FADE_LOG2=0, layer2=0xABC, blank=0 -> rgb_out=0xABC 2 cycles after input; hs/vs/blank delayed 2.
//  3. overlay_en[3]=1, key=0x000, layer3=0xF00 -> 0xF00; layer3=0x000 -> base pixel; blank_in=1 -> 0x000.
//  4. FADE_LOG2=2, from layer=0x000, to layer=0xFFF -> frames 0x000,0x333,0x777,0xBBB, then 0xFFF, busy falls.
//  5. sel_in change mid-line without trigger -> no effect; sel_in=NUM_LAYERS -> ignored; change at k=2 -> k restarts 0.
//  6. rst_in during FADING at k=1 -> busy=0, cur_sel=0 next cycle, output layer0 after 2-cycle latency.

Source files
------------

// File: rtl/screen_compositor.sv
// screen_compositor: picks one of NUM_LAYERS full-screen RGB sources as the
// base picture, crossfades between bases over 2^FADE_LOG2 frames, draws keyed
// overlay layers on top and delays the VGA timing signals to stay aligned.
//
// Ports
//   clk_in, rst_in     pixel clock, synchronous active-high reset
//   frame_trigger_in   one-cycle pulse per frame; the only time sel_in is sampled
//   hsync/vsync/blank  timing in; *_out versions are delayed by 2 cycles
//   layer_rgb_in       packed 4:4:4 sources, layer i at [12*i+11:12*i]
//   sel_in             requested base layer (values >= NUM_LAYERS are ignored)
//   overlay_en_in      per-layer overlay enable (ignored for the current base)
//   key_color_in       transparent colour for overlays
//   rgb_out            composited pixel, forced to 0 while blanked
//   fade_busy_out      high while a crossfade is in progress
module screen_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned FADE_LOG2  = 4,
  localparam int unsigned SEL_W     = $clog2(NUM_LAYERS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    frame_trigger_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    blank_in,
  input  logic [12*NUM_LAYERS-1:0] layer_rgb_in,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_LAYERS-1:0]   overlay_en_in,
  input  logic [11:0]             key_color_in,
  output logic [11:0]             rgb_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    blank_out,
  output logic                    fade_busy_out
);

  // k counter width, blend weight width, blend product width
  localparam int unsigned KW = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
  localparam int unsigned WW = FADE_LOG2 + 1;
  localparam int unsigned PW = 4 + FADE_LOG2 + 1;
  localparam logic [KW-1:0] K_LAST = KW'((1 << FADE_LOG2) - 1);
  localparam logic [WW-1:0] K_FULL = WW'(1 << FADE_LOG2);

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_e;

  // Selection / fade control state
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]  from_sel_q, from_sel_d;
  logic [KW-1:0]     k_q, k_d;
  logic              busy_q, busy_d;
  logic              sel_ok;
  logic              sel_new;

  // Stage 1 pipeline
  logic [11:0]       from_pix_q, from_pix_d;
  logic [11:0]       to_pix_q, to_pix_d;
  logic              fade_s1_q;
  logic [KW-1:0]     k_s1_q;
  logic              ovl_hit_q, ovl_hit_d;
  logic [11:0]       ovl_pix_q, ovl_pix_d;
  logic              hs1_q, vs1_q, blank1_q;

  // Stage 2 pipeline
  logic [11:0]       blend_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs2_q, vs2_q, blank2_q;

  // Control state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cur_sel_q  <= '0;
      from_sel_q <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      from_sel_q <= from_sel_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: selection changes only on a frame trigger
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    from_sel_d = from_sel_q;
    k_d        = k_q;
    sel_ok     = (32'(sel_in) < NUM_LAYERS);
    sel_new    = frame_trigger_in && sel_ok && (sel_in != cur_sel_q);

    case (state_q)
      IDLE: begin
        if (sel_new) begin
          from_sel_d = cur_sel_q;
          cur_sel_d  = sel_in;
          k_d        = '0;
          // Zero-length fade is an instant switch
          if (FADE_LOG2 != 0) state_d = FADING;
        end
      end
      FADING: begin
        if (sel_new) begin
          // New request mid-fade restarts from the current target
          from_sel_d = cur_sel_q;
          cur_sel_d  = sel_in;
          k_d        = '0;
        end else if (frame_trigger_in) begin
          if (k_q == K_LAST) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FADING);
  end

  // Stage 1 source pick and overlay search (highest enabled opaque layer wins)
  always_comb begin
    from_pix_d = layer_rgb_in[12*from_sel_q +: 12];
    to_pix_d   = layer_rgb_in[12*cur_sel_q +: 12];
    ovl_hit_d  = 1'b0;
    ovl_pix_d  = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (overlay_en_in[i] && (SEL_W'(i) != cur_sel_q) &&
          (layer_rgb_in[12*i +: 12] != key_color_in)) begin
        ovl_hit_d = 1'b1;
        ovl_pix_d = layer_rgb_in[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      from_pix_q <= '0;
      to_pix_q   <= '0;
      fade_s1_q  <= 1'b0;
      k_s1_q     <= '0;
      ovl_hit_q  <= 1'b0;
      ovl_pix_q  <= '0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      blank1_q   <= 1'b1;
    end else begin
      from_pix_q <= from_pix_d;
      to_pix_q   <= to_pix_d;
      fade_s1_q  <= (state_q == FADING);
      k_s1_q     <= k_q;
      ovl_hit_q  <= ovl_hit_d;
      ovl_pix_q  <= ovl_pix_d;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      blank1_q   <= blank_in;
    end
  end

  // Stage 2 per-channel blend: (from*(2^L-k) + to*k) >> L, truncated
  always_comb begin
    blend_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      blend_d[4*ch +: 4] = 4'((PW'(from_pix_q[4*ch +: 4]) * PW'(K_FULL - WW'(k_s1_q)) +
                              PW'(to_pix_q[4*ch +: 4]) * PW'(k_s1_q)) >> FADE_LOG2);
    end
  end

  // Stage 2 compose: base, then overlay, then blanking
  always_comb begin
    rgb_d = fade_s1_q ? blend_d : to_pix_q;
    if (ovl_hit_q) rgb_d = ovl_pix_q;
    if (blank1_q)  rgb_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rgb_q    <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      blank2_q <= 1'b1;
    end else begin
      rgb_q    <= rgb_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= blank1_q;
    end
  end

  assign rgb_out       = rgb_q;
  assign hsync_out     = hs2_q;
  assign vsync_out     = vs2_q;
  assign blank_out     = blank2_q;
  assign fade_busy_out = busy_q;

endmodule
